lifo_fifo_buf: RTL and testbench

Parametrised single-clock stack/queue buffer, the next generation of the team's `lifo` block. It adds:
- a run-time selectable LIFO/FIFO mode;
- simultaneous read+write in the same cycle;
- almost-full and almost-empty thresholds;
- sticky overflow and underflow error flags.

It sits between packet/command producers and consumers wherever a depth-bounded reorder buffer is needed, and replaces `lifo` in new designs.

---
 rtl/lifo_fifo_buf.sv | 122 ++++++++++++
 tb/tb_lifo_fifo_buf.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_fifo_buf.sv
// Single-clock stack/queue buffer with run-time LIFO/FIFO mode, simultaneous
// read+write, almost-full/empty thresholds and sticky overflow/underflow flags.
module lifo_fifo_buf #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4,
    parameter int AF_THR = 2**AWIDTH - 2,
    parameter int AE_THR = 2
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              mode_i,
    input  logic              wrreq_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              rdreq_i,
    output logic [DWIDTH-1:0] q_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              almost_empty_o,
    output logic              almost_full_o,
    output logic [AWIDTH:0]   usedw_o,
    input  logic              err_clr_i,
    output logic              ovf_o,
    output logic              udf_o
);

    typedef enum logic {
        MODE_LIFO = 1'b0,
        MODE_FIFO = 1'b1
    } mode_e;

    localparam logic [AWIDTH:0] AF_LVL = (AWIDTH+1)'(AF_THR);
    localparam logic [AWIDTH:0] AE_LVL = (AWIDTH+1)'(AE_THR);

    logic [DWIDTH-1:0] mem [2**AWIDTH];
    logic [DWIDTH-1:0] q;
    logic [AWIDTH:0]   count;
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    mode_e             mode;
    logic              ovf;
    logic              udf;

    logic              full;
    logic              empty;
    logic              wr_acc;
    logic              rd_acc;
    logic [AWIDTH-1:0] top;
    logic [AWIDTH-1:0] wr_addr;
    logic [AWIDTH-1:0] rd_addr;

    // Count can only reach 2**AWIDTH, so its MSB alone marks full.
    assign full   = count[AWIDTH];
    assign empty  = (count == '0);
    assign wr_acc = wrreq_i && (!full || rdreq_i);
    assign rd_acc = rdreq_i && !empty;
    assign top    = count[AWIDTH-1:0] - AWIDTH'(1);

    always_comb begin
        rd_addr = rd_ptr;
        wr_addr = wr_ptr;
        if (mode == MODE_LIFO) begin
            rd_addr = top;
            // A simultaneous push/pop in LIFO replaces the top in place.
            wr_addr = rd_acc ? top : count[AWIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem[wr_addr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            q      <= '0;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            mode   <= MODE_LIFO;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (rd_acc) begin
                q <= mem[rd_addr];
            end

            case ({wr_acc, rd_acc})
                2'b10:   count <= count + (AWIDTH+1)'(1);
                2'b01:   count <= count - (AWIDTH+1)'(1);
                default: count <= count;
            endcase

            if (empty && !wrreq_i) begin
                mode   <= mode_e'(mode_i);
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else if (mode == MODE_FIFO) begin
                if (wr_acc) wr_ptr <= wr_ptr + AWIDTH'(1);
                if (rd_acc) rd_ptr <= rd_ptr + AWIDTH'(1);
            end

            if (err_clr_i) begin
                ovf <= 1'b0;
                udf <= 1'b0;
            end else begin
                if (wrreq_i && !wr_acc) ovf <= 1'b1;
                if (rdreq_i && !rd_acc) udf <= 1'b1;
            end
        end
    end

    assign q_o            = q;
    assign usedw_o        = count;
    assign empty_o        = empty;
    assign full_o         = full;
    assign almost_empty_o = (count <= AE_LVL);
    assign almost_full_o  = (count >= AF_LVL);
    assign ovf_o          = ovf;
    assign udf_o          = udf;

endmodule

// File: tb/tb_lifo_fifo_buf.sv
// Directed self-checking bench for lifo_fifo_buf (DWIDTH=8, AWIDTH=4,
// AF_THR=14, AE_THR=2).
module tb_lifo_fifo_buf;

    logic       clk_i = 1'b0;
    logic       arstn_i = 1'b0;
    logic       mode_i = 1'b0;
    logic       wrreq_i = 1'b0;
    logic [7:0] data_i = '0;
    logic       rdreq_i = 1'b0;
    logic       err_clr_i = 1'b0;
    logic [7:0] q_o;
    logic       empty_o, full_o, almost_empty_o, almost_full_o;
    logic [4:0] usedw_o;
    logic       ovf_o, udf_o;

    int tests = 0;
    int fails = 0;

    lifo_fifo_buf #(
        .DWIDTH(8),
        .AWIDTH(4),
        .AF_THR(14),
        .AE_THR(2)
    ) dut (
        .clk_i(clk_i),
        .arstn_i(arstn_i),
        .mode_i(mode_i),
        .wrreq_i(wrreq_i),
        .data_i(data_i),
        .rdreq_i(rdreq_i),
        .q_o(q_o),
        .empty_o(empty_o),
        .full_o(full_o),
        .almost_empty_o(almost_empty_o),
        .almost_full_o(almost_full_o),
        .usedw_o(usedw_o),
        .err_clr_i(err_clr_i),
        .ovf_o(ovf_o),
        .udf_o(udf_o)
    );

    always #5 clk_i = ~clk_i;

    // Apply one cycle of stimulus and return 1 time unit after the edge.
    task automatic step(input logic wr, input logic rd, input logic [7:0] d);
        wrreq_i = wr;
        rdreq_i = rd;
        data_i  = d;
        @(posedge clk_i);
        #1;
        wrreq_i = 1'b0;
        rdreq_i = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        tests++;
        if ({q_o, usedw_o, empty_o, full_o, almost_empty_o, almost_full_o, ovf_o, udf_o}
            !== {8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: q=%h usedw=%0d e=%b f=%b ae=%b af=%b ovf=%b udf=%b, want q=00 usedw=0 e=1 f=0 ae=1 af=0 ovf=0 udf=0",
                     q_o, usedw_o, empty_o, full_o, almost_empty_o, almost_full_o, ovf_o, udf_o);
        end
        @(negedge clk_i);
        arstn_i = 1'b1;
        mode_i  = 1'b0;
        step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_lifo_fill_drain();
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 1'b0, 8'(k));
            tests++;
            if (usedw_o !== 5'(k) || almost_full_o !== (k >= 14) ||
                almost_empty_o !== (k <= 2) || full_o !== (k == 16) || empty_o !== 1'b0) begin
                fails++;
                $display("FAIL lifo_fill[%0d]: usedw=%0d af=%b ae=%b f=%b e=%b, want usedw=%0d af=%b ae=%b f=%b e=0",
                         k, usedw_o, almost_full_o, almost_empty_o, full_o, empty_o,
                         k, (k >= 14), (k <= 2), (k == 16));
            end
        end
        step(1'b1, 1'b0, 8'hEE);
        tests++;
        if (ovf_o !== 1'b1 || usedw_o !== 5'd16 || udf_o !== 1'b0) begin
            fails++;
            $display("FAIL ovf_when_full: ovf=%b usedw=%0d udf=%b, want ovf=1 usedw=16 udf=0",
                     ovf_o, usedw_o, udf_o);
        end
        for (int k = 16; k >= 1; k--) begin
            step(1'b0, 1'b1, 8'h00);
            tests++;
            if (q_o !== 8'(k) || usedw_o !== 5'(k - 1) || empty_o !== (k == 1)) begin
                fails++;
                $display("FAIL lifo_drain[%0d]: q=%h usedw=%0d e=%b, want q=%h usedw=%0d e=%b",
                         k, q_o, usedw_o, empty_o, 8'(k), k - 1, (k == 1));
            end
        end
        step(1'b0, 1'b1, 8'h00);
        tests++;
        if (udf_o !== 1'b1 || q_o !== 8'h01 || usedw_o !== 5'd0 || ovf_o !== 1'b1) begin
            fails++;
            $display("FAIL udf_when_empty: udf=%b q=%h usedw=%0d ovf=%b, want udf=1 q=01 usedw=0 ovf=1",
                     udf_o, q_o, usedw_o, ovf_o);
        end
        err_clr_i = 1'b1;
        step(1'b0, 1'b1, 8'h00);
        err_clr_i = 1'b0;
        tests++;
        if (ovf_o !== 1'b0 || udf_o !== 1'b0) begin
            fails++;
            $display("FAIL err_clear: ovf=%b udf=%b, want ovf=0 udf=0 (clear beats set)", ovf_o, udf_o);
        end
    endtask

    task automatic test_fifo_wrap();
        mode_i = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 8'(8'h20 + k));
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, 8'h00);
            tests++;
            if (q_o !== 8'(8'h20 + k)) begin
                fails++;
                $display("FAIL fifo_rd1[%0d]: q=%h, want %h", k, q_o, 8'(8'h20 + k));
            end
        end
        for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 8'(8'h40 + k));
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b1, 8'h00);
            tests++;
            if (q_o !== 8'(8'h40 + k)) begin
                fails++;
                $display("FAIL fifo_wrap_rd[%0d]: q=%h, want %h", k, q_o, 8'(8'h40 + k));
            end
        end
        tests++;
        if (usedw_o !== 5'd0 || empty_o !== 1'b1) begin
            fails++;
            $display("FAIL fifo_end_empty: usedw=%0d e=%b, want usedw=0 e=1", usedw_o, empty_o);
        end
    endtask

    task automatic test_fifo_full_simul();
        for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 8'(8'h60 + k));
        step(1'b1, 1'b1, 8'h99);
        tests++;
        if (q_o !== 8'h60 || usedw_o !== 5'd16 || ovf_o !== 1'b0 || full_o !== 1'b1) begin
            fails++;
            $display("FAIL fifo_full_rw: q=%h usedw=%0d ovf=%b f=%b, want q=60 usedw=16 ovf=0 f=1",
                     q_o, usedw_o, ovf_o, full_o);
        end
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 1'b1, 8'h00);
            tests++;
            if (q_o !== ((k == 16) ? 8'h99 : 8'(8'h60 + k))) begin
                fails++;
                $display("FAIL fifo_full_drain[%0d]: q=%h, want %h",
                         k, q_o, (k == 16) ? 8'h99 : 8'(8'h60 + k));
            end
        end
    endtask

    task automatic test_lifo_simul();
        mode_i = 1'b0;
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'hA0);
        step(1'b1, 1'b0, 8'hA1);
        step(1'b1, 1'b1, 8'h55);
        tests++;
        if (q_o !== 8'hA1 || usedw_o !== 5'd2) begin
            fails++;
            $display("FAIL lifo_rw: q=%h usedw=%0d, want q=a1 usedw=2", q_o, usedw_o);
        end
        step(1'b0, 1'b1, 8'h00);
        tests++;
        if (q_o !== 8'h55 || usedw_o !== 5'd1) begin
            fails++;
            $display("FAIL lifo_rw_next: q=%h usedw=%0d, want q=55 usedw=1", q_o, usedw_o);
        end
        step(1'b0, 1'b1, 8'h00);
        tests++;
        if (q_o !== 8'hA0 || empty_o !== 1'b1) begin
            fails++;
            $display("FAIL lifo_rw_bottom: q=%h e=%b, want q=a0 e=1", q_o, empty_o);
        end
        step(1'b1, 1'b1, 8'hC3);
        tests++;
        if (udf_o !== 1'b1 || usedw_o !== 5'd1 || q_o !== 8'hA0) begin
            fails++;
            $display("FAIL lifo_rw_empty: udf=%b usedw=%0d q=%h, want udf=1 usedw=1 q=a0",
                     udf_o, usedw_o, q_o);
        end
        step(1'b0, 1'b1, 8'h00);
        tests++;
        if (q_o !== 8'hC3 || usedw_o !== 5'd0) begin
            fails++;
            $display("FAIL lifo_rw_empty_rd: q=%h usedw=%0d, want q=c3 usedw=0", q_o, usedw_o);
        end
        err_clr_i = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        err_clr_i = 1'b0;
    endtask

    task automatic test_mode_lock();
        step(1'b1, 1'b0, 8'h31);
        mode_i = 1'b1;
        step(1'b1, 1'b0, 8'h32);
        step(1'b1, 1'b0, 8'h33);
        for (int k = 3; k >= 1; k--) begin
            step(1'b0, 1'b1, 8'h00);
            tests++;
            if (q_o !== 8'(8'h30 + k)) begin
                fails++;
                $display("FAIL mode_lock_lifo[%0d]: q=%h, want %h", k, q_o, 8'(8'h30 + k));
            end
        end
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h01);
        step(1'b1, 1'b0, 8'h02);
        step(1'b0, 1'b1, 8'h00);
        tests++;
        if (q_o !== 8'h01) begin
            fails++;
            $display("FAIL mode_switch_fifo: q=%h, want 01", q_o);
        end
        step(1'b0, 1'b1, 8'h00);
        tests++;
        if (q_o !== 8'h02 || empty_o !== 1'b1) begin
            fails++;
            $display("FAIL mode_switch_fifo2: q=%h e=%b, want q=02 e=1", q_o, empty_o);
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b0, 8'h12);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        tests++;
        if (q_o !== 8'h12 || udf_o !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset: q=%h udf=%b, want q=12 udf=1", q_o, udf_o);
        end
        step(1'b1, 1'b0, 8'h13);
        wrreq_i = 1'b1;
        data_i  = 8'h14;
        #2;
        arstn_i = 1'b0;
        #1;
        tests++;
        if ({q_o, usedw_o, empty_o, full_o, almost_empty_o, almost_full_o, ovf_o, udf_o}
            !== {8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL async_reset: q=%h usedw=%0d e=%b f=%b ae=%b af=%b ovf=%b udf=%b, want q=00 usedw=0 e=1 f=0 ae=1 af=0 ovf=0 udf=0",
                     q_o, usedw_o, empty_o, full_o, almost_empty_o, almost_full_o, ovf_o, udf_o);
        end
        wrreq_i = 1'b0;
        mode_i  = 1'b0;
        @(negedge clk_i);
        arstn_i = 1'b1;
        step(1'b1, 1'b0, 8'h77);
        step(1'b0, 1'b1, 8'h00);
        tests++;
        if (q_o !== 8'h77 || usedw_o !== 5'd0) begin
            fails++;
            $display("FAIL post_reset_rw: q=%h usedw=%0d, want q=77 usedw=0", q_o, usedw_o);
        end
    endtask

    initial begin
        test_reset();
        test_lifo_fill_drain();
        test_fifo_wrap();
        test_fifo_full_simul();
        test_lifo_simul();
        test_mode_lock();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
